// File: rtl/vec_cpu_pkg.sv
// Shared vector-CPU definitions: ALU opcodes, ALU sequencer states and beat-count helper.
// Processor control imports the opcode enum from here as well.
package vec_cpu_pkg;

   typedef enum logic [3:0] {
      OpAndVe = 4'b0000,
      OpAndVv = 4'b0001,
      OpOrVe  = 4'b0010,
      OpOrVv  = 4'b0011,
      OpXorVe = 4'b0100,
      OpXorVv = 4'b0101,
      OpShr   = 4'b0110,
      OpShl   = 4'b0111,
      OpRor   = 4'b1000,
      OpRol   = 4'b1001,
      OpAddVv = 4'b1010,
      OpAddVe = 4'b1011,
      OpSubVv = 4'b1100,
      OpSubVe = 4'b1101,
      OpRsv0  = 4'b1110,
      OpRsv1  = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } alu_state_e;

   function automatic int unsigned calc_beats(input int unsigned vec_len,
                                              input int unsigned lanes);
      return vec_len / lanes;
   endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// Combinational single-element ALU slice; one instance per lane of vec_alu_seq.
module vec_alu_lane
   import vec_cpu_pkg::*;
#(
   parameter int unsigned ELEM_W = 8
) (
   input  alu_op_e           op,
   input  logic [ELEM_W-1:0] a,
   input  logic [ELEM_W-1:0] b,
   input  logic [ELEM_W-1:0] esc,
   output logic [ELEM_W-1:0] res
);

   localparam int unsigned SH_W = (ELEM_W > 1) ? $clog2(ELEM_W) : 1;

   logic [SH_W-1:0] sh;
   logic [SH_W:0]   sh_inv;

   assign sh     = esc[SH_W-1:0];
   // Complementary shift for rotates; sh=0 gives ELEM_W, which shifts everything out.
   assign sh_inv = (SH_W + 1)'(ELEM_W) - {1'b0, sh};

   always_comb begin
      res = '0;
      case (op)
         OpAndVe: res = a & esc;
         OpAndVv: res = a & b;
         OpOrVe:  res = a | esc;
         OpOrVv:  res = a | b;
         OpXorVe: res = a ^ esc;
         OpXorVv: res = a ^ b;
         OpShr:   res = a >> sh;
         OpShl:   res = a << sh;
         OpRor:   res = (a >> sh) | (a << sh_inv);
         OpRol:   res = (a << sh) | (a >> sh_inv);
         OpAddVv: res = a + b;
         OpAddVe: res = a + esc;
         OpSubVv: res = a - b;
         OpSubVe: res = a - esc;
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/vec_alu_seq.sv
// Multi-cycle vector ALU: latches operands on start, computes LANES elements per beat,
// then holds the full result with alu_rdy high until the next start.
module vec_alu_seq
   import vec_cpu_pkg::*;
#(
   parameter int unsigned VEC_LEN = 8,
   parameter int unsigned ELEM_W  = 8,
   parameter int unsigned LANES   = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      alu_st,
   input  logic [3:0]                alu_op,
   input  logic [VEC_LEN*ELEM_W-1:0] vec_a,
   input  logic [VEC_LEN*ELEM_W-1:0] vec_b,
   input  logic [ELEM_W-1:0]         esc,
   output logic                      alu_rdy,
   output logic [VEC_LEN*ELEM_W-1:0] vec_res
);

   localparam int unsigned BEATS = calc_beats(VEC_LEN, LANES);
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

   alu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   alu_op_e           op_q, op_d;
   logic [ELEM_W-1:0] esc_q, esc_d;
   logic [ELEM_W-1:0] a_q [VEC_LEN];
   logic [ELEM_W-1:0] a_d [VEC_LEN];
   logic [ELEM_W-1:0] b_q [VEC_LEN];
   logic [ELEM_W-1:0] b_d [VEC_LEN];
   logic [ELEM_W-1:0] res_q [VEC_LEN];
   logic [ELEM_W-1:0] res_d [VEC_LEN];
   logic [ELEM_W-1:0] a_in [VEC_LEN];
   logic [ELEM_W-1:0] b_in [VEC_LEN];

   logic [IDX_W-1:0]  base_idx;
   logic [IDX_W-1:0]  lane_idx [LANES];
   logic [ELEM_W-1:0] lane_res [LANES];

   for (genvar g = 0; g < VEC_LEN; g++) begin : g_elem
      assign a_in[g] = vec_a[g*ELEM_W +: ELEM_W];
      assign b_in[g] = vec_b[g*ELEM_W +: ELEM_W];
      assign vec_res[g*ELEM_W +: ELEM_W] = res_q[g];
   end

   assign base_idx = IDX_W'(cnt_q) * IDX_W'(LANES);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = base_idx + IDX_W'(l);

      vec_alu_lane #(
         .ELEM_W (ELEM_W)
      ) u_lane (
         .op  (op_q),
         .a   (a_q[lane_idx[l]]),
         .b   (b_q[lane_idx[l]]),
         .esc (esc_q),
         .res (lane_res[l])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      esc_d   = esc_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      case (state_q)
         StIdle, StDone: begin
            if (alu_st) begin
               op_d    = alu_op_e'(alu_op);
               esc_d   = esc;
               a_d     = a_in;
               b_d     = b_in;
               cnt_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            // Start requests are ignored here; decode re-presents them once DONE.
            for (int l = 0; l < LANES; l++) begin
               res_d[lane_idx[l]] = lane_res[l];
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BEATS - 1)) begin
               cnt_d   = '0;
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= OpAndVe;
         esc_q   <= '0;
         for (int i = 0; i < VEC_LEN; i++) begin
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            res_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         esc_q   <= esc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

   assign alu_rdy = (state_q == StDone);

endmodule

// File: tb/tb_vec_alu_seq.sv
// Self-checking bench for vec_alu_seq: directed table, corner sequences, random vs. model.
module tb_vec_alu_seq;

   localparam int unsigned VEC_LEN = 8;
   localparam int unsigned ELEM_W  = 8;
   localparam int unsigned LANES   = 2;
   localparam int unsigned BEATS   = VEC_LEN / LANES;
   localparam int unsigned VW      = VEC_LEN * ELEM_W;

   logic          clk;
   logic          rst_n;
   logic          alu_st;
   logic [3:0]    alu_op;
   logic [VW-1:0] vec_a;
   logic [VW-1:0] vec_b;
   logic [7:0]    esc;
   logic          alu_rdy;
   logic [VW-1:0] vec_res;

   int n_checks = 0;
   int n_fail   = 0;

   vec_alu_seq #(
      .VEC_LEN (VEC_LEN),
      .ELEM_W  (ELEM_W),
      .LANES   (LANES)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .alu_st  (alu_st),
      .alu_op  (alu_op),
      .vec_a   (vec_a),
      .vec_b   (vec_b),
      .esc     (esc),
      .alu_rdy (alu_rdy),
      .vec_res (vec_res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] e;
      logic [7:0] r;
   } vec_t;

   vec_t tbl [11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   function automatic logic [VW-1:0] rep(input logic [7:0] x);
      return {VEC_LEN{x}};
   endfunction

   // Reference element computed from the operation definitions with integer arithmetic.
   function automatic logic [7:0] model_elem(input int op, input int a, input int b,
                                             input int e);
      int sh;
      int r;
      logic [7:0] av;
      logic [7:0] rv;
      sh = e % ELEM_W;
      av = 8'(a);
      rv = '0;
      r  = 0;
      case (op)
         0:  r = a & e;
         1:  r = a & b;
         2:  r = a | e;
         3:  r = a | b;
         4:  r = a ^ e;
         5:  r = a ^ b;
         6:  r = a / (1 << sh);
         7:  r = a * (1 << sh);
         8: begin
            for (int k = 0; k < 8; k++) rv[k] = av[(k + sh) % 8];
            r = int'(rv);
         end
         9: begin
            for (int k = 0; k < 8; k++) rv[(k + sh) % 8] = av[k];
            r = int'(rv);
         end
         10: r = a + b;
         11: r = a + e;
         12: r = a - b;
         13: r = a - e;
         default: r = 0;
      endcase
      return 8'(r);
   endfunction

   function automatic logic [VW-1:0] model_vec(input int op, input logic [VW-1:0] a,
                                               input logic [VW-1:0] b, input logic [7:0] e);
      logic [VW-1:0] r;
      for (int i = 0; i < VEC_LEN; i++) begin
         r[i*8 +: 8] = model_elem(op, int'(a[i*8 +: 8]), int'(b[i*8 +: 8]), int'(e));
      end
      return r;
   endfunction

   // Start one op, scramble the operand inputs after capture, then check latency and result.
   task automatic run_op(input string nm, input logic [3:0] op, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input logic [7:0] e,
                         input logic [VW-1:0] exp);
      int lat;
      alu_op = op;
      vec_a  = a;
      vec_b  = b;
      esc    = e;
      alu_st = 1'b1;
      tick();
      alu_st = 1'b0;
      vec_a  = ~a;
      vec_b  = ~b;
      esc    = ~e;
      lat    = 0;
      while (!alu_rdy && lat < 20) begin
         tick();
         lat++;
      end
      check({nm, "_latency"}, VW'(lat), VW'(BEATS));
      check({nm, "_result"}, vec_res, exp);
   endtask

   initial begin
      logic [VW-1:0] ra;
      logic [VW-1:0] rb;
      logic [VW-1:0] exp;
      logic [7:0]    re;
      logic [3:0]    rop;
      int            pulses;

      tbl[0]  = '{4'hA, 8'hF0, 8'h20, 8'h00, 8'h10};
      tbl[1]  = '{4'h9, 8'h81, 8'h00, 8'h09, 8'h03};
      tbl[2]  = '{4'h6, 8'h81, 8'h00, 8'h09, 8'h40};
      tbl[3]  = '{4'h8, 8'h81, 8'h00, 8'h09, 8'hC0};
      tbl[4]  = '{4'h7, 8'h81, 8'h00, 8'h0A, 8'h04};
      tbl[5]  = '{4'h5, 8'h5A, 8'hFF, 8'h00, 8'hA5};
      tbl[6]  = '{4'hC, 8'h10, 8'h20, 8'h00, 8'hF0};
      tbl[7]  = '{4'h2, 8'h0F, 8'h00, 8'hF0, 8'hFF};
      tbl[8]  = '{4'h0, 8'h3C, 8'h00, 8'h0F, 8'h0C};
      tbl[9]  = '{4'h8, 8'h81, 8'h00, 8'h08, 8'h81};
      tbl[10] = '{4'hE, 8'h12, 8'h34, 8'h56, 8'h00};

      rst_n  = 1'b0;
      alu_st = 1'b0;
      alu_op = '0;
      vec_a  = '0;
      vec_b  = '0;
      esc    = '0;
      tick();
      tick();
      check("reset_rdy", VW'(alu_rdy), VW'(0));
      check("reset_res", vec_res, '0);
      rst_n = 1'b1;
      tick();
      check("idle_rdy", VW'(alu_rdy), VW'(0));

      for (int t = 0; t < 11; t++) begin
         run_op($sformatf("tbl%0d_op%h", t, tbl[t].op), tbl[t].op, rep(tbl[t].a),
                rep(tbl[t].b), tbl[t].e, rep(tbl[t].r));
      end

      // Subtract-ve with operand change after capture; latched A must be used.
      for (int i = 0; i < VEC_LEN; i++) begin
         ra[i*8 +: 8] = 8'(i);
         exp[i*8 +: 8] = 8'(i - 3);
      end
      run_op("sub_ve_latch", 4'hD, ra, '0, 8'h03, exp);
      check("sub_ve_elem0", VW'(vec_res[7:0]), VW'(8'hFD));
      check("sub_ve_elem7", VW'(vec_res[63:56]), VW'(8'h04));

      // Reset asserted during beat 2 aborts immediately with no later rdy.
      alu_op = 4'hA;
      vec_a  = rep(8'h11);
      vec_b  = rep(8'h22);
      alu_st = 1'b1;
      tick();
      alu_st = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("midreset_rdy", VW'(alu_rdy), VW'(0));
      check("midreset_res", vec_res, '0);
      tick();
      rst_n  = 1'b1;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (alu_rdy) pulses++;
      end
      check("midreset_no_rdy", VW'(pulses), VW'(0));

      // Back-to-back with alu_st held high throughout.
      ra     = {$urandom, $urandom};
      rb     = {$urandom, $urandom};
      alu_op = 4'h1;
      vec_a  = ra;
      vec_b  = rb;
      alu_st = 1'b1;
      tick();
      alu_op = 4'h3;
      for (int k = 1; k < BEATS; k++) begin
         tick();
         check($sformatf("b2b_busy1_c%0d", k), VW'(alu_rdy), VW'(0));
      end
      tick();
      check("b2b_done1_rdy", VW'(alu_rdy), VW'(1));
      check("b2b_done1_res", vec_res, model_vec(1, ra, rb, 8'h00));
      tick();
      check("b2b_restart_rdy", VW'(alu_rdy), VW'(0));
      for (int k = 1; k < BEATS; k++) begin
         tick();
         check($sformatf("b2b_busy2_c%0d", k), VW'(alu_rdy), VW'(0));
      end
      tick();
      alu_st = 1'b0;
      check("b2b_done2_rdy", VW'(alu_rdy), VW'(1));
      check("b2b_done2_res", vec_res, model_vec(3, ra, rb, 8'h00));

      // Undefined op with random operands.
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_op("undef_op_f", 4'hF, ra, rb, 8'($urandom), '0);

      // Randomised ops against the reference model.
      for (int t = 0; t < 40; t++) begin
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         re  = 8'($urandom);
         rop = 4'($urandom_range(0, 15));
         run_op($sformatf("rand%0d_op%h", t, rop), rop, ra, rb, re,
                model_vec(int'(rop), ra, rb, re));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
